// File: rtl/toll_gate_ctrl_p.sv
// Single-lane toll-gate controller: entry/transit/decision/barrier sequencing.
// Define DEBOUNCE_EN to insert a DEB_CYC-sample debounce filter on each sensor.
`timescale 1ns/1ps
module toll_gate_ctrl_p #(
    parameter int CNT_W    = 4,
    parameter int TIME_W   = 16,
    parameter int CALC_TMO = 1000,
    parameter int DEB_CYC  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sensor1,
    input  logic              sensor2,
    input  logic              sensor3,
    input  logic [1:0]        valid_Epass,
    input  logic              enable,
    output logic              init,
    output logic              count,
    output logic              cal,
    output logic              up,
    output logic              dis,
    output logic              deny,
    output logic              tmo_err,
    output logic [CNT_W-1:0]  occ,
    output logic              occ_ovf,
    output logic [TIME_W-1:0] transit_time
);

    localparam int DW = $clog2(CALC_TMO) + 1;

    typedef enum logic [1:0] {IDLE, TIMING, CALC, OPEN} state_t;

    state_t            state;
    logic [2:0]        raw;
    logic [2:0]        filt;
    logic [2:0]        s_q;
    logic [2:0]        s_p;
    logic              s1_rise;
    logic              s2_rise;
    logic              s3_fall;
    logic              inc;
    logic              dec;
    logic [CNT_W-1:0]  occ_nxt;
    logic [TIME_W-1:0] timer;
    logic [TIME_W-1:0] tcnt;
    logic [DW-1:0]     dcnt;
    logic              exit_seen;

    assign raw = {sensor3, sensor2, sensor1};

`ifdef DEBOUNCE_EN
    localparam int BW = $clog2(DEB_CYC) + 1;

    for (genvar i = 0; i < 3; i++) begin : g_deb
        logic [BW-1:0] cnt;
        logic          f;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt <= '0;
                f   <= 1'b0;
            end else if (raw[i] == f) begin
                cnt <= '0;
            end else if (cnt == BW'(DEB_CYC - 1)) begin
                cnt <= '0;
                f   <= raw[i];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign filt[i] = f;
    end
`else
    assign filt = raw;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_q <= '0;
            s_p <= '0;
        end else begin
            s_q <= filt;
            s_p <= s_q;
        end
    end

    assign s1_rise = s_q[0] & ~s_p[0];
    assign s2_rise = s_q[1] & ~s_p[1];
    assign s3_fall = ~s_q[2] & s_p[2];

    // Simultaneous entry and exit cancel out.
    assign inc = s1_rise & ~s3_fall;
    assign dec = s3_fall & ~s1_rise;

    always_comb begin
        occ_nxt = occ;
        if (inc && occ != '1)
            occ_nxt = occ + 1'b1;
        else if (dec && occ != '0)
            occ_nxt = occ - 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ     <= '0;
            occ_ovf <= 1'b0;
        end else begin
            occ <= occ_nxt;
            if (inc && occ == '1)
                occ_ovf <= 1'b1;
        end
    end

    // tcnt is the number of TIMING cycles including the current one.
    assign tcnt = timer + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            timer        <= '0;
            dcnt         <= '0;
            exit_seen    <= 1'b0;
            transit_time <= '0;
            up           <= 1'b0;
            dis          <= 1'b0;
            deny         <= 1'b0;
            tmo_err      <= 1'b0;
        end else begin
            up      <= 1'b0;
            dis     <= 1'b0;
            deny    <= 1'b0;
            tmo_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (s1_rise) begin
                        timer <= '0;
                        state <= TIMING;
                    end
                end
                TIMING: begin
                    if (s2_rise) begin
                        transit_time <= tcnt;
                        dcnt         <= '0;
                        state        <= CALC;
                    end else if (tcnt == '1) begin
                        tmo_err <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        timer <= tcnt;
                    end
                end
                CALC: begin
                    if (valid_Epass == 2'b10) begin
                        up        <= 1'b1;
                        exit_seen <= 1'b0;
                        state     <= OPEN;
                    end else if (valid_Epass == 2'b01) begin
                        deny  <= 1'b1;
                        state <= IDLE;
                    end else if (dcnt == DW'(CALC_TMO - 1)) begin
                        deny  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                OPEN: begin
                    if (exit_seen && enable) begin
                        dis       <= 1'b1;
                        exit_seen <= 1'b0;
                        state     <= IDLE;
                    end else if (s3_fall && occ_nxt == '0) begin
                        exit_seen <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign init  = (state == IDLE);
    assign count = (state == TIMING);
    assign cal   = (state == CALC);

endmodule

// File: tb/tb_toll_gate_ctrl_p.sv
// Randomised scoreboard bench for toll_gate_ctrl_p.
// Honours DEBOUNCE_EN for event latency and the glitch-rejection case.
`timescale 1ns/1ps
module tb_toll_gate_ctrl_p;

    localparam int CNT_W    = 2;
    localparam int TIME_W   = 6;
    localparam int CALC_TMO = 20;
    localparam int DEB_CYC  = 4;
`ifdef DEBOUNCE_EN
    localparam int LAT = DEB_CYC + 2;
`else
    localparam int LAT = 2;
`endif
    localparam int TMAX = (1 << TIME_W) - 1;
    localparam int OMAX = (1 << CNT_W) - 1;
    localparam logic [3:0] K_UP   = 4'b1000;
    localparam logic [3:0] K_DIS  = 4'b0100;
    localparam logic [3:0] K_DENY = 4'b0010;
    localparam logic [3:0] K_TMO  = 4'b0001;

    logic              clk;
    logic              reset_n;
    logic              sensor1;
    logic              sensor2;
    logic              sensor3;
    logic [1:0]        valid;
    logic              enable;
    logic              init;
    logic              count;
    logic              cal;
    logic              up;
    logic              dis;
    logic              deny;
    logic              tmo_err;
    logic [CNT_W-1:0]  occ;
    logic              occ_ovf;
    logic [TIME_W-1:0] transit_time;

    toll_gate_ctrl_p #(
        .CNT_W(CNT_W), .TIME_W(TIME_W),
        .CALC_TMO(CALC_TMO), .DEB_CYC(DEB_CYC)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .sensor1(sensor1), .sensor2(sensor2), .sensor3(sensor3),
        .valid_Epass(valid), .enable(enable),
        .init(init), .count(count), .cal(cal),
        .up(up), .dis(dis), .deny(deny), .tmo_err(tmo_err),
        .occ(occ), .occ_ovf(occ_ovf), .transit_time(transit_time)
    );

    typedef struct {
        logic [3:0] kind;
        int         cyc_at;
        int         tt;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   occ_m = 0;
    int   tt_m = 0;
    int   ovf_m = 0;
    bit   mon_on = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [3:0] k, input int c, input int tt);
        exp_t e;
        e.kind   = k;
        e.cyc_at = c;
        e.tt     = tt;
        q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Lane occupancy as the number of vehicles that entered and not left.
    function automatic void s1_event();
        if (occ_m == OMAX) ovf_m = 1;
        else occ_m++;
    endfunction

    function automatic void s3_event();
        if (occ_m > 0) occ_m--;
    endfunction

    always @(negedge clk) begin
        logic [3:0] p;
        exp_t       e;
        if (mon_on) begin
            p = {up, dis, deny, tmo_err};
            if (q.size() > 0 && q[0].cyc_at < cyc) begin
                chk("missed_pulse_cycle", cyc, q[0].cyc_at);
                void'(q.pop_front());
            end
            if (p != 4'b0000) begin
                if (q.size() == 0) begin
                    chk("unexpected_pulse", int'(p), 0);
                end else begin
                    e = q.pop_front();
                    chk("pulse_kind", int'(p), int'(e.kind));
                    chk("pulse_cycle", cyc, e.cyc_at);
                    chk("transit_time", int'(transit_time), e.tt);
                end
            end
        end
    end

    task automatic drain();
        int t;
        sensor3 = 1'b1;
        wait_cyc(cyc + 2);
        sensor3 = 1'b0;
        s3_event();
        t = cyc;
        wait_cyc(t + LAT + 1);
        chk("occ_after_exit", int'(occ), occ_m);
        chk("idle_after_exit", int'(init), 1);
    endtask

    task automatic do_pass(input int g, input int d,
                           input logic [1:0] dc, input int ed);
        int n0;
        int ce;
        int f;
        int e;
        int dis_at;
        n0 = cyc;
        enable = 1'b0;
        sensor1 = 1'b1;
        s1_event();
        wait_cyc(n0 + 2);
        sensor1 = 1'b0;
        wait_cyc(n0 + LAT);
        chk("enter_timing", int'(count), 1);
        wait_cyc(n0 + g);
        sensor2 = 1'b1;
        wait_cyc(n0 + g + 2);
        sensor2 = 1'b0;
        ce = n0 + g + LAT;
        wait_cyc(ce);
        chk("enter_calc", int'(cal), 1);
        chk("occ_in_calc", int'(occ), occ_m);
        if (dc == 2'b10 || dc == 2'b01) begin
            wait_cyc(ce + d);
            valid = dc;
            push(dc == 2'b10 ? K_UP : K_DENY, ce + d + 1, g);
            wait_cyc(ce + d + 1);
            valid = 2'b00;
        end else begin
            valid = dc;
            push(K_DENY, ce + CALC_TMO, g);
            wait_cyc(ce + CALC_TMO);
            valid = 2'b00;
        end
        tt_m = g;
        if (dc == 2'b10) begin
            wait_cyc(cyc + 1);
            sensor3 = 1'b1;
            f = cyc + 2;
            wait_cyc(f);
            sensor3 = 1'b0;
            s3_event();
            e = f + ed;
            wait_cyc(e);
            enable = 1'b1;
            dis_at = (f + LAT + 1 > e + 1) ? f + LAT + 1 : e + 1;
            push(K_DIS, dis_at, g);
            wait_cyc(dis_at + 1);
            chk("idle_after_dis", int'(init), 1);
            chk("occ_after_dis", int'(occ), occ_m);
            enable = 1'b0;
        end else begin
            wait_cyc(cyc + 1);
            chk("idle_after_deny", int'(init), 1);
            chk("occ_held_after_deny", int'(occ), occ_m);
            drain();
        end
        wait_cyc(cyc + 3);
    endtask

    task automatic transit_tmo();
        int n0;
        n0 = cyc;
        sensor1 = 1'b1;
        s1_event();
        wait_cyc(n0 + 2);
        sensor1 = 1'b0;
        push(K_TMO, n0 + LAT + TMAX, tt_m);
        wait_cyc(n0 + LAT + TMAX - 1);
        chk("timing_before_tmo", int'(count), 1);
        wait_cyc(n0 + LAT + TMAX);
        chk("idle_after_tmo", int'(init), 1);
        drain();
    endtask

    task automatic occupancy();
        int t;
        t = cyc;
        push(K_TMO, t + LAT + TMAX, tt_m);
        for (int i = 0; i < 4; i++) begin
            wait_cyc(t + 4 * i);
            sensor1 = 1'b1;
            s1_event();
            wait_cyc(t + 4 * i + 2);
            sensor1 = 1'b0;
        end
        wait_cyc(t + 12 + LAT + 1);
        chk("occ_saturated", int'(occ), occ_m);
        chk("occ_ovf_set", int'(occ_ovf), ovf_m);
        wait_cyc(t + 16);
        sensor3 = 1'b1;
        wait_cyc(t + 20);
        sensor1 = 1'b1;
        sensor3 = 1'b0;
        wait_cyc(t + 22);
        sensor1 = 1'b0;
        wait_cyc(t + 20 + LAT + 1);
        chk("occ_simultaneous", int'(occ), occ_m);
        chk("still_timing", int'(count), 1);
        wait_cyc(t + LAT + TMAX + 1);
        chk("idle_after_occ_tmo", int'(init), 1);
        for (int i = 0; i < OMAX + 1; i++) drain();
        chk("occ_ovf_sticky", int'(occ_ovf), ovf_m);
    endtask

    task automatic midop_reset();
        int n0;
        int ce;
        n0 = cyc;
        sensor1 = 1'b1;
        s1_event();
        wait_cyc(n0 + 2);
        sensor1 = 1'b0;
        wait_cyc(n0 + 10);
        sensor2 = 1'b1;
        wait_cyc(n0 + 12);
        sensor2 = 1'b0;
        ce = n0 + 10 + LAT;
        wait_cyc(ce);
        valid = 2'b10;
        push(K_UP, ce + 1, 10);
        wait_cyc(ce + 1);
        valid = 2'b00;
        tt_m = 10;
        wait_cyc(ce + 3);
        chk("open_not_idle", int'(init), 0);
        reset_n = 1'b0;
        #1;
        occ_m = 0;
        ovf_m = 0;
        tt_m = 0;
        chk("rst_init", int'(init), 1);
        chk("rst_count", int'(count), 0);
        chk("rst_cal", int'(cal), 0);
        chk("rst_pulses", int'({up, dis, deny, tmo_err}), 0);
        chk("rst_occ", int'(occ), occ_m);
        chk("rst_ovf", int'(occ_ovf), ovf_m);
        chk("rst_tt", int'(transit_time), tt_m);
        @(negedge clk);
        reset_n = 1'b1;
        wait_cyc(cyc + 3);
        chk("idle_after_release", int'(init), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        sensor1 = 1'b0;
        sensor2 = 1'b0;
        sensor3 = 1'b0;
        valid   = 2'b00;
        enable  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_init", int'(init), 1);
        chk("reset_count_cal", int'({count, cal}), 0);
        chk("reset_pulses", int'({up, dis, deny, tmo_err}), 0);
        chk("reset_occ", int'(occ), 0);
        chk("reset_ovf", int'(occ_ovf), 0);
        chk("reset_tt", int'(transit_time), 0);
        reset_n = 1'b1;
        mon_on  = 1'b1;
        wait_cyc(cyc + 3);

        do_pass(50, 0, 2'b10, 0);
        for (int i = 0; i < 4; i++)
            do_pass($urandom_range(8, 40), $urandom_range(0, 5),
                    2'b10, $urandom_range(0, 6));
        do_pass($urandom_range(8, 40), CALC_TMO - 1, 2'b10, 0);
        do_pass($urandom_range(8, 40), $urandom_range(0, 5), 2'b01, 0);
        do_pass($urandom_range(8, 40), 0, 2'b00, 0);
        do_pass($urandom_range(8, 40), 0, 2'b11, 0);
        transit_tmo();
        occupancy();
        midop_reset();
`ifdef DEBOUNCE_EN
        begin
            int t;
            t = cyc;
            sensor1 = 1'b1;
            wait_cyc(t + DEB_CYC - 1);
            sensor1 = 1'b0;
            wait_cyc(t + DEB_CYC + LAT + 3);
            chk("glitch_idle", int'(init), 1);
            chk("glitch_occ", int'(occ), occ_m);
        end
`endif
        do_pass($urandom_range(8, 40), $urandom_range(0, 5),
                2'b10, $urandom_range(0, 6));

        wait_cyc(cyc + 5);
        chk("scoreboard_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
